// File: rtl/dfp_arbiter.sv
// Two-client arbiter between the I-cache and D-cache DFP ports and the single
// cacheline burst adaptor; one transaction in flight, held stable until mem_resp.
module dfp_arbiter #(
    parameter int unsigned FIXED_DPRIO = 0,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LINE_W      = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] i_dfp_addr,
    input  logic              i_dfp_read,
    output logic [LINE_W-1:0] i_dfp_rdata,
    output logic              i_dfp_resp,

    input  logic [ADDR_W-1:0] d_dfp_addr,
    input  logic              d_dfp_read,
    input  logic              d_dfp_write,
    input  logic [LINE_W-1:0] d_dfp_wdata,
    output logic [LINE_W-1:0] d_dfp_rdata,
    output logic              d_dfp_resp,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {GNT_I, GNT_D} gnt_t;

    state_t             state, state_next;
    gnt_t               grant, last_grant;
    logic [ADDR_W-1:0]  addr_q;
    logic               read_q;
    logic               write_q;
    logic [LINE_W-1:0]  wdata_q;
    logic [LINE_W-1:0]  i_rdata_q;
    logic [LINE_W-1:0]  d_rdata_q;

    logic i_req, d_req, pick_d, accept;

    assign i_req  = i_dfp_read;
    assign d_req  = d_dfp_read | d_dfp_write;
    // D wins when alone, when it has fixed priority, or when I was served last.
    assign pick_d = d_req && (!i_req || (FIXED_DPRIO != 0) || (last_grant == GNT_I));
    assign accept = (state == IDLE) && (i_req || d_req);

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_req || d_req) state_next = BUSY;
            BUSY:    if (mem_resp)       state_next = RESP;
            RESP:                        state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // NOTE: the line registers are reset as well, because a reset must clear every output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= GNT_I;
            last_grant <= GNT_I;
            addr_q     <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state <= state_next;
            if (accept) begin
                grant      <= pick_d ? GNT_D : GNT_I;
                last_grant <= pick_d ? GNT_D : GNT_I;
                addr_q     <= pick_d ? d_dfp_addr : i_dfp_addr;
                write_q    <= pick_d && d_dfp_write;
                read_q     <= pick_d ? !d_dfp_write : 1'b1;
                if (pick_d && d_dfp_write) wdata_q <= d_dfp_wdata;
            end
            if ((state == BUSY) && mem_resp && read_q) begin
                if (grant == GNT_D) d_rdata_q <= mem_rdata;
                else                i_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_read    = (state == BUSY) && read_q;
    assign mem_write   = (state == BUSY) && write_q;
    assign i_dfp_rdata = i_rdata_q;
    assign d_dfp_rdata = d_rdata_q;
    assign i_dfp_resp  = (state == RESP) && (grant == GNT_I);
    assign d_dfp_resp  = (state == RESP) && (grant == GNT_D);

    // Read and write together is illegal; the write is issued and this flags it.
    rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(d_dfp_read && d_dfp_write))
        else $warning("dfp_arbiter: d_dfp_read and d_dfp_write both high");

endmodule

// File: tb/tb_dfp_arbiter.sv
// Directed bench for dfp_arbiter: a round-robin instance plus a fixed-D-priority
// instance share stimulus; the adaptor is modelled by hand-timed mem_resp pulses.
module tb_dfp_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    localparam logic [LW-1:0] LINE_A = {{7{32'hAAAA_AAAA}}, 32'hAAAA_0001};
    localparam logic [LW-1:0] WLINE  = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
    localparam logic [LW-1:0] W2     = {8{32'h5A5A_0F0F}};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] i_dfp_addr = '0;
    logic          i_dfp_read = 1'b0;
    logic [AW-1:0] d_dfp_addr = '0;
    logic          d_dfp_read = 1'b0;
    logic          d_dfp_write = 1'b0;
    logic [LW-1:0] d_dfp_wdata = '0;
    logic [LW-1:0] mem_rdata = '0;
    logic          mem_resp = 1'b0;

    logic [LW-1:0] i_dfp_rdata, d_dfp_rdata, mem_wdata;
    logic          i_dfp_resp, d_dfp_resp, mem_read, mem_write;
    logic [AW-1:0] mem_addr;

    logic [LW-1:0] fx_i_dfp_rdata, fx_d_dfp_rdata, fx_mem_wdata;
    logic          fx_i_dfp_resp, fx_d_dfp_resp, fx_mem_read, fx_mem_write;
    logic [AW-1:0] fx_mem_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dfp_arbiter #(.FIXED_DPRIO(0), .ADDR_W(AW), .LINE_W(LW)) u_rr (
        .clk(clk), .rst(rst),
        .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read),
        .i_dfp_rdata(i_dfp_rdata), .i_dfp_resp(i_dfp_resp),
        .d_dfp_addr(d_dfp_addr), .d_dfp_read(d_dfp_read), .d_dfp_write(d_dfp_write),
        .d_dfp_wdata(d_dfp_wdata), .d_dfp_rdata(d_dfp_rdata), .d_dfp_resp(d_dfp_resp),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    dfp_arbiter #(.FIXED_DPRIO(1), .ADDR_W(AW), .LINE_W(LW)) u_fx (
        .clk(clk), .rst(rst),
        .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read),
        .i_dfp_rdata(fx_i_dfp_rdata), .i_dfp_resp(fx_i_dfp_resp),
        .d_dfp_addr(d_dfp_addr), .d_dfp_read(d_dfp_read), .d_dfp_write(d_dfp_write),
        .d_dfp_wdata(d_dfp_wdata), .d_dfp_rdata(fx_d_dfp_rdata), .d_dfp_resp(fx_d_dfp_resp),
        .mem_addr(fx_mem_addr), .mem_read(fx_mem_read), .mem_write(fx_mem_write),
        .mem_wdata(fx_mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rr_line(input int t);
        rr_line = {8{28'hC0DE_000, t[3:0]}};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if ({mem_read, mem_write, i_dfp_resp, d_dfp_resp} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000", {mem_read, mem_write, i_dfp_resp, d_dfp_resp});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_mem_bus got addr=%h wdata_nonzero=%0b exp 0", mem_addr, |mem_wdata);
        end
        checks++;
        if (i_dfp_rdata !== '0 || d_dfp_rdata !== '0) begin
            failures++;
            $display("FAIL reset_rdata got i_nz=%0b d_nz=%0b exp 0", |i_dfp_rdata, |d_dfp_rdata);
        end
        checks++;
        if (fx_i_dfp_rdata !== '0 || fx_mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_fx got i_nz=%0b wdata_nz=%0b exp 0", |fx_i_dfp_rdata, |fx_mem_wdata);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_i_read();
        i_dfp_addr = 32'h1000_0040;
        i_dfp_read = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            checks++;
            if ({mem_read, mem_write, mem_addr} !== {1'b1, 1'b0, 32'h1000_0040}) begin
                failures++;
                $display("FAIL ird_busy_c%0d got rd=%0b wr=%0b addr=%h exp rd=1 wr=0 addr=10000040",
                         c, mem_read, mem_write, mem_addr);
            end
            if (c == 7) begin
                mem_resp  = 1'b1;
                mem_rdata = LINE_A;
            end
        end
        step();
        mem_resp = 1'b0;
        checks++;
        if ({i_dfp_resp, d_dfp_resp, mem_read} !== 3'b100) begin
            failures++;
            $display("FAIL ird_resp got i=%0b d=%0b rd=%0b exp i=1 d=0 rd=0", i_dfp_resp, d_dfp_resp, mem_read);
        end
        checks++;
        if (i_dfp_rdata !== LINE_A) begin
            failures++;
            $display("FAIL ird_rdata got=%h exp=%h", i_dfp_rdata, LINE_A);
        end
        i_dfp_read = 1'b0;
        step();
        checks++;
        if ({i_dfp_resp, d_dfp_resp, mem_read} !== 3'b000) begin
            failures++;
            $display("FAIL ird_pulse_end got i=%0b d=%0b rd=%0b exp 0", i_dfp_resp, d_dfp_resp, mem_read);
        end
    endtask

    task automatic test_d_write();
        d_dfp_addr  = 32'h2000_0000;
        d_dfp_write = 1'b1;
        d_dfp_wdata = WLINE;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 2) d_dfp_wdata = '1;
            checks++;
            if ({mem_write, mem_read, mem_addr} !== {1'b1, 1'b0, 32'h2000_0000} || mem_wdata !== WLINE) begin
                failures++;
                $display("FAIL dwr_busy_c%0d got wr=%0b rd=%0b addr=%h wdata=%h exp wr=1 rd=0 addr=20000000 wdata=%h",
                         c, mem_write, mem_read, mem_addr, mem_wdata, WLINE);
            end
            if (c == 4) begin
                mem_resp  = 1'b1;
                mem_rdata = {8{32'hDEAD_BEEF}};
            end
        end
        step();
        mem_resp = 1'b0;
        checks++;
        if ({d_dfp_resp, i_dfp_resp, mem_write} !== 3'b100) begin
            failures++;
            $display("FAIL dwr_resp got d=%0b i=%0b wr=%0b exp d=1 i=0 wr=0", d_dfp_resp, i_dfp_resp, mem_write);
        end
        checks++;
        if (d_dfp_rdata !== '0 || i_dfp_rdata !== LINE_A) begin
            failures++;
            $display("FAIL dwr_rdata_kept got d=%h i=%h exp d=0 i=%h", d_dfp_rdata, i_dfp_rdata, LINE_A);
        end
        d_dfp_write = 1'b0;
        step();
        checks++;
        if (d_dfp_resp !== 1'b0) begin
            failures++;
            $display("FAIL dwr_pulse_end got=%0b exp=0", d_dfp_resp);
        end
    endtask

    task automatic test_round_robin();
        logic exp_d;
        rst = 1'b0;
        step();
        rst = 1'b1;
        i_dfp_addr = 32'h3000_0000;
        d_dfp_addr = 32'h4000_0000;
        i_dfp_read = 1'b1;
        d_dfp_read = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_d = (t % 2 == 0);
            step();
            checks++;
            if (mem_addr !== (exp_d ? 32'h4000_0000 : 32'h3000_0000) || mem_read !== 1'b1) begin
                failures++;
                $display("FAIL rr_grant_t%0d got addr=%h rd=%0b exp addr=%h rd=1",
                         t, mem_addr, mem_read, exp_d ? 32'h4000_0000 : 32'h3000_0000);
            end
            checks++;
            if ({fx_mem_addr, fx_mem_read, fx_mem_write} !== {32'h4000_0000, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL fx_grant_t%0d got addr=%h rd=%0b wr=%0b exp addr=40000000 rd=1 wr=0",
                         t, fx_mem_addr, fx_mem_read, fx_mem_write);
            end
            mem_resp  = 1'b1;
            mem_rdata = rr_line(t);
            step();
            mem_resp = 1'b0;
            checks++;
            if ({i_dfp_resp, d_dfp_resp} !== (exp_d ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL rr_resp_t%0d got i=%0b d=%0b exp d=%0b", t, i_dfp_resp, d_dfp_resp, exp_d);
            end
            checks++;
            if ((exp_d ? d_dfp_rdata : i_dfp_rdata) !== rr_line(t)) begin
                failures++;
                $display("FAIL rr_rdata_t%0d got=%h exp=%h", t, exp_d ? d_dfp_rdata : i_dfp_rdata, rr_line(t));
            end
            checks++;
            if ({fx_i_dfp_resp, fx_d_dfp_resp} !== 2'b01 || fx_d_dfp_rdata !== rr_line(t)) begin
                failures++;
                $display("FAIL fx_resp_t%0d got i=%0b d=%0b rdata=%h exp i=0 d=1 rdata=%h",
                         t, fx_i_dfp_resp, fx_d_dfp_resp, fx_d_dfp_rdata, rr_line(t));
            end
            step();
        end
        i_dfp_read = 1'b0;
        d_dfp_read = 1'b0;
        step();
    endtask

    task automatic test_spurious_resp();
        mem_resp  = 1'b1;
        mem_rdata = {8{32'hBAD0_BAD0}};
        step();
        mem_resp = 1'b0;
        checks++;
        if ({mem_read, mem_write, i_dfp_resp, d_dfp_resp} !== 4'b0000) begin
            failures++;
            $display("FAIL spur_idle_c1 got=%b exp=0000", {mem_read, mem_write, i_dfp_resp, d_dfp_resp});
        end
        step();
        checks++;
        if ({mem_read, mem_write, i_dfp_resp, d_dfp_resp} !== 4'b0000 || i_dfp_rdata !== rr_line(3)) begin
            failures++;
            $display("FAIL spur_idle_c2 got ctrl=%b i_rdata=%h exp ctrl=0000 i_rdata=%h",
                     {mem_read, mem_write, i_dfp_resp, d_dfp_resp}, i_dfp_rdata, rr_line(3));
        end
        i_dfp_addr = 32'h5000_0080;
        i_dfp_read = 1'b1;
        step();
        checks++;
        if ({mem_read, mem_addr} !== {1'b1, 32'h5000_0080}) begin
            failures++;
            $display("FAIL spur_grant got rd=%0b addr=%h exp rd=1 addr=50000080", mem_read, mem_addr);
        end
        mem_resp  = 1'b1;
        mem_rdata = {8{32'hB0B0_0001}};
        step();
        mem_rdata  = {8{32'hC0C0_0002}};
        i_dfp_read = 1'b0;
        checks++;
        if (i_dfp_resp !== 1'b1) begin
            failures++;
            $display("FAIL spur_resp got=%0b exp=1", i_dfp_resp);
        end
        step();
        mem_resp = 1'b0;
        checks++;
        if ({i_dfp_resp, mem_read} !== 2'b00 || i_dfp_rdata !== {8{32'hB0B0_0001}}) begin
            failures++;
            $display("FAIL spur_in_resp got resp=%0b rd=%0b rdata=%h exp resp=0 rd=0 rdata=%h",
                     i_dfp_resp, mem_read, i_dfp_rdata, {8{32'hB0B0_0001}});
        end
        step();
        checks++;
        if ({mem_read, mem_write, i_dfp_resp, d_dfp_resp} !== 4'b0000) begin
            failures++;
            $display("FAIL spur_settle got=%b exp=0000", {mem_read, mem_write, i_dfp_resp, d_dfp_resp});
        end
    endtask

    task automatic test_reset_mid_busy();
        d_dfp_addr = 32'h6000_0000;
        d_dfp_read = 1'b1;
        i_dfp_addr = 32'h7000_0040;
        i_dfp_read = 1'b1;
        step();
        checks++;
        if ({mem_read, mem_addr} !== {1'b1, 32'h6000_0000}) begin
            failures++;
            $display("FAIL rstb_grant got rd=%0b addr=%h exp rd=1 addr=60000000", mem_read, mem_addr);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write, i_dfp_resp, d_dfp_resp} !== 4'b0000 || mem_addr !== '0) begin
            failures++;
            $display("FAIL rstb_async got ctrl=%b addr=%h exp ctrl=0000 addr=0",
                     {mem_read, mem_write, i_dfp_resp, d_dfp_resp}, mem_addr);
        end
        checks++;
        if (i_dfp_rdata !== '0 || d_dfp_rdata !== '0) begin
            failures++;
            $display("FAIL rstb_rdata got i_nz=%0b d_nz=%0b exp 0", |i_dfp_rdata, |d_dfp_rdata);
        end
        d_dfp_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        checks++;
        if ({mem_read, mem_addr, i_dfp_resp, d_dfp_resp} !== {1'b1, 32'h7000_0040, 2'b00}) begin
            failures++;
            $display("FAIL rstb_regrant got rd=%0b addr=%h i=%0b d=%0b exp rd=1 addr=70000040 i=0 d=0",
                     mem_read, mem_addr, i_dfp_resp, d_dfp_resp);
        end
        mem_resp  = 1'b1;
        mem_rdata = {8{32'h1234_5678}};
        step();
        mem_resp   = 1'b0;
        i_dfp_read = 1'b0;
        checks++;
        if ({i_dfp_resp, d_dfp_resp} !== 2'b10 || i_dfp_rdata !== {8{32'h1234_5678}}) begin
            failures++;
            $display("FAIL rstb_resp got i=%0b d=%0b rdata=%h exp i=1 d=0 rdata=%h",
                     i_dfp_resp, d_dfp_resp, i_dfp_rdata, {8{32'h1234_5678}});
        end
        step();
    endtask

    task automatic test_rw_conflict();
        d_dfp_addr  = 32'h8000_0000;
        d_dfp_read  = 1'b1;
        d_dfp_write = 1'b1;
        d_dfp_wdata = W2;
        step();
        checks++;
        if ({mem_write, mem_read} !== 2'b10 || mem_wdata !== W2 || mem_addr !== 32'h8000_0000) begin
            failures++;
            $display("FAIL rw_issue got wr=%0b rd=%0b addr=%h wdata=%h exp wr=1 rd=0 addr=80000000 wdata=%h",
                     mem_write, mem_read, mem_addr, mem_wdata, W2);
        end
        mem_resp  = 1'b1;
        mem_rdata = {8{32'hFEED_FACE}};
        step();
        mem_resp    = 1'b0;
        d_dfp_read  = 1'b0;
        d_dfp_write = 1'b0;
        checks++;
        if ({d_dfp_resp, i_dfp_resp} !== 2'b10 || d_dfp_rdata !== '0) begin
            failures++;
            $display("FAIL rw_resp got d=%0b i=%0b d_rdata=%h exp d=1 i=0 d_rdata=0",
                     d_dfp_resp, i_dfp_resp, d_dfp_rdata);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_round_robin();
        test_spurious_resp();
        test_reset_mid_busy();
        test_rw_conflict();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dfp_arbiter.md
Name: dfp_arbiter

Overview:
- Two-client arbiter between the I-cache and D-cache DFP ports and the single cacheline burst adaptor DFP port.
- Latches the winning request and holds address, write data and command stable for the whole adaptor transaction.
- Captures the returned 256-bit line and returns it to the granted cache with a one-cycle response pulse.
- Guarantees the adaptor sees its request deasserted in the cycle after its response, so no spurious back-to-back transaction is issued.

Parameters:
- FIXED_DPRIO, 0: 0 = round-robin when both caches request; 1 = D-cache always wins.
- ADDR_W, 32: DFP address width.
- LINE_W, 256: cacheline width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- i_dfp_addr  input  ADDR_W  I-cache line address (32-byte aligned)
- i_dfp_read  input  1  I-cache read request, level, held until i_dfp_resp
- i_dfp_rdata  output  LINE_W  line returned to I-cache
- i_dfp_resp  output  1  one-cycle I-cache completion pulse
- d_dfp_addr  input  ADDR_W  D-cache line address
- d_dfp_read  input  1  D-cache read request, held until d_dfp_resp
- d_dfp_write  input  1  D-cache writeback request, held until d_dfp_resp
- d_dfp_wdata  input  LINE_W  D-cache writeback line
- d_dfp_rdata  output  LINE_W  line returned to D-cache
- d_dfp_resp  output  1  one-cycle D-cache completion pulse
- mem_addr  output  ADDR_W  to adaptor address_in
- mem_read  output  1  to adaptor dfp_read
- mem_write  output  1  to adaptor dfp_write
- mem_wdata  output  LINE_W  to adaptor line_in
- mem_rdata  input  LINE_W  from adaptor line_out
- mem_resp  input  1  from adaptor completion pulse

Behaviour:
- Reset (rst=0, async): state=IDLE, last_grant=I. All outputs and latched registers are 0. This applies mid-transaction too: the in-flight request is dropped and no resp is issued.
- States: IDLE, BUSY, RESP.
- IDLE:
  - mem_read, mem_write and both resp outputs are 0.
  - A request exists if i_dfp_read, d_dfp_read or d_dfp_write is high.
  - Winner selection:
    - Only one cache requesting: that cache wins.
    - Both requesting, FIXED_DPRIO=1: D wins.
    - Both requesting, FIXED_DPRIO=0: the cache not equal to last_grant wins.
  - On a request: latch grant id, address, read/write command and wdata (wdata only for a D-cache write), update last_grant, go to BUSY.
- BUSY:
  - mem_addr, mem_wdata, mem_read and mem_write are driven from the latched registers and are stable every cycle.
  - Exactly one of mem_read/mem_write is high.
  - Cache inputs are ignored.
  - On mem_resp=1: capture mem_rdata into the granted cache's rdata register (capture on reads only; writes leave rdata unchanged), go to RESP.
- RESP:
  - mem_read and mem_write are 0.
  - The granted cache's resp is 1 for exactly one cycle; the other cache's resp stays 0.
  - Next state is IDLE.
- Latency: request in IDLE at cycle 0 → mem_read/mem_write high at cycle 1. mem_resp at cycle N → cache resp at N+1. Next grant in IDLE is possible at N+2.
- i_dfp_rdata and d_dfp_rdata hold their last captured line until the next capture.
- d_dfp_read and d_dfp_write both high is illegal. The write takes precedence, and a simulation-only assertion fires.
- mem_resp outside BUSY is ignored.
- A cache dropping its request while not granted loses nothing, because no state is held for it.
- Back-to-back requests from the same cache, with the other cache idle, are granted on every IDLE.

Test Plan:
- I-cache read only, addr 0x1000_0040 → mem_read=1 with mem_addr=0x1000_0040 from cycle 1. Adaptor returns line 0xAAAA…_0001 with mem_resp at cycle 7 → i_dfp_resp=1 at cycle 8 only, i_dfp_rdata=0xAAAA…_0001, mem_read=0 at cycle 8.
- D-cache writeback, addr 0x2000_0000, wdata = 4 beats 0x11…/0x22…/0x33…/0x44… → mem_write and mem_wdata stable for every BUSY cycle. mem_resp → single d_dfp_resp, d_dfp_rdata unchanged.
- Both caches request continuously, FIXED_DPRIO=0, after reset → grants alternate D, I, D, I over 4 transactions. With FIXED_DPRIO=1 → four consecutive D grants.
- Spurious mem_resp in IDLE, and a second mem_resp while in RESP → no cache resp, no state change.
- rst asserted during BUSY of a D read → all outputs 0 immediately. After release, a held i_dfp_read is granted cleanly with no stale resp.
- d_dfp_read and d_dfp_write both high → write is issued and the assertion is flagged.
